// File: rtl/alu_accum_pkg.sv
// Shared encodings for the ALU/accumulator slice: datapath width,
// FSM state codes and one-hot op select bit positions.
package alu_accum_pkg;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned MODE_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    HOLD  = 2'b10,
    CLEAR = 2'b11
  } state_t;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_XOR = 4;
  localparam int unsigned OP_NOT = 5;

  localparam int unsigned MODE_CLEAR   = 0;
  localparam int unsigned MODE_LOAD    = 1;
  localparam int unsigned MODE_PERSIST = 2;

  // Mode select decode, clear beats load beats persist.
  function automatic state_t decode_mode(input logic [MODE_W-1:0] sel);
    state_t st;
    st = IDLE;
    if (sel[MODE_CLEAR])        st = CLEAR;
    else if (sel[MODE_LOAD])    st = LOAD;
    else if (sel[MODE_PERSIST]) st = HOLD;
    return st;
  endfunction

endpackage

// File: rtl/alu_op_unit.sv
// Combinational ALU: lowest set op_sel bit selects the function,
// all-zero op_sel passes A through. Optional carry/borrow output
// exists only when ALU_FLAGS_EN is defined.
module alu_op_unit
  import alu_accum_pkg::*;
#(
  parameter int unsigned W = alu_accum_pkg::WIDTH
) (
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [OP_W-1:0] op_sel,
`ifdef ALU_FLAGS_EN
  output logic            carry,
`endif
  output logic [W-1:0]    result
);

  // Priority-ordered function select; carry is the ADD carry-out or SUB borrow.
  always_comb begin
    result = a;
`ifdef ALU_FLAGS_EN
    carry  = 1'b0;
`endif
    if (op_sel[OP_ADD]) begin
`ifdef ALU_FLAGS_EN
      {carry, result} = (W+1)'(a) + (W+1)'(b);
`else
      result = a + b;
`endif
    end else if (op_sel[OP_SUB]) begin
      result = a - b;
`ifdef ALU_FLAGS_EN
      carry  = (a < b);
`endif
    end else if (op_sel[OP_AND]) begin
      result = a & b;
    end else if (op_sel[OP_OR]) begin
      result = a | b;
    end else if (op_sel[OP_XOR]) begin
      result = a ^ b;
    end else if (op_sel[OP_NOT]) begin
      result = ~a;
    end
  end

endmodule

// File: rtl/alu_accum_fsm.sv
// ALU with registered accumulator sequenced by a 4-state mode FSM.
// Optional {carry, zero} flags output enabled by macro ALU_FLAGS_EN.
module alu_accum_fsm
  import alu_accum_pkg::*;
#(
  parameter int unsigned WIDTH = alu_accum_pkg::WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        in_sel,
  input  logic [WIDTH-1:0]  num1,
  input  logic [WIDTH-1:0]  num2,
  input  logic [5:0]        out_sel,
`ifdef ALU_FLAGS_EN
  output logic [1:0]        flags,
`endif
  output logic [WIDTH-1:0]  out,
  output logic [1:0]        currState,
  output logic [1:0]        nextState
);

  state_t            curr_st;
  state_t            next_st;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  alu_res;
`ifdef ALU_FLAGS_EN
  logic              alu_carry;
  logic [1:0]        flags_q;
`endif

  // Next state follows the mode select continuously, independent of reset.
  always_comb begin
    next_st = decode_mode(in_sel);
  end

  // LOAD takes operand A from num1; otherwise chain on the stored value.
  always_comb begin
    op_a = acc;
    if (next_st == LOAD) op_a = num1;
  end

  alu_op_unit #(.W(WIDTH)) u_alu (
    .a      (op_a),
    .b      (num2),
    .op_sel (out_sel),
`ifdef ALU_FLAGS_EN
    .carry  (alu_carry),
`endif
    .result (alu_res)
  );

  // State register and accumulator update keyed on the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      curr_st <= IDLE;
      acc     <= '0;
`ifdef ALU_FLAGS_EN
      flags_q <= 2'b00;
`endif
    end else begin
      curr_st <= next_st;
      case (next_st)
        CLEAR: begin
          acc     <= '0;
`ifdef ALU_FLAGS_EN
          flags_q <= 2'b00;
`endif
        end
        LOAD, HOLD: begin
          acc     <= alu_res;
`ifdef ALU_FLAGS_EN
          flags_q <= {alu_carry, (alu_res == '0)};
`endif
        end
        default: begin
          acc     <= acc;
        end
      endcase
    end
  end

  assign out       = acc;
  assign currState = curr_st;
  assign nextState = next_st;
`ifdef ALU_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_alu_accum_fsm.sv
// Bench for alu_accum_fsm: directed vector table plus randomized traffic
// against an arithmetic reference model. Flags checked when ALU_FLAGS_EN.
module tb_alu_accum_fsm;

  logic       clk;
  logic       reset;
  logic [2:0] in_sel;
  logic [7:0] num1, num2;
  logic [5:0] out_sel;
  logic [7:0] out;
  logic [1:0] currState, nextState;
`ifdef ALU_FLAGS_EN
  logic [1:0] flags;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_acc = 0;
  int m_state = 0;
  int m_carry = 0;
  int m_zero = 0;

  alu_accum_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .in_sel    (in_sel),
    .num1      (num1),
    .num2      (num2),
    .out_sel   (out_sel),
`ifdef ALU_FLAGS_EN
    .flags     (flags),
`endif
    .out       (out),
    .currState (currState),
    .nextState (nextState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] exp_out;
    logic [1:0] exp_cs;
    logic [1:0] exp_ns;
    logic [1:0] exp_fl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [2:0] s, logic [7:0] a, logic [7:0] b,
                              logic [5:0] op, logic [7:0] eo, logic [1:0] cs,
                              logic [1:0] ns, logic [1:0] fl);
    vec_t v;
    v.rst = r; v.sel = s; v.a = a; v.b = b; v.op = op;
    v.exp_out = eo; v.exp_cs = cs; v.exp_ns = ns; v.exp_fl = fl;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mode priority: clear(3) > load(1) > persist(2) > idle(0)
  function automatic int model_ns(input logic [2:0] s);
    if (s[0]) return 3;
    if (s[1]) return 1;
    if (s[2]) return 2;
    return 0;
  endfunction

  function automatic int model_alu(input int a, input int b, input logic [5:0] op);
    if (op[0]) return (a + b) % 256;
    if (op[1]) return (a - b + 256) % 256;
    if (op[2]) return a & b;
    if (op[3]) return a | b;
    if (op[4]) return a ^ b;
    if (op[5]) return 255 - a;
    return a;
  endfunction

  function automatic int model_carry(input int a, input int b, input logic [5:0] op);
    if (op[0]) return (a + b > 255) ? 1 : 0;
    if (op[1]) return (a < b) ? 1 : 0;
    return 0;
  endfunction

  // One clock of stimulus: drive at negedge, check combinational next state,
  // advance the model on the posedge and compare registered outputs.
  task automatic apply(input logic r, input logic [2:0] s, input logic [7:0] a,
                       input logic [7:0] b, input logic [5:0] op);
    int ns, opa;
    @(negedge clk);
    reset = r; in_sel = s; num1 = a; num2 = b; out_sel = op;
    #1;
    ns = model_ns(s);
    check("nextState", int'(nextState), ns);
    @(posedge clk);
    if (r) begin
      m_state = 0; m_acc = 0; m_carry = 0; m_zero = 0;
    end else begin
      m_state = ns;
      if (ns == 3) begin
        m_acc = 0; m_carry = 0; m_zero = 0;
      end else if (ns == 1 || ns == 2) begin
        opa = (ns == 1) ? int'(a) : m_acc;
        m_carry = model_carry(opa, int'(b), op);
        m_acc   = model_alu(opa, int'(b), op);
        m_zero  = (m_acc == 0) ? 1 : 0;
      end
    end
    #1;
    check("out", int'(out), m_acc);
    check("currState", int'(currState), m_state);
`ifdef ALU_FLAGS_EN
    check("flags", int'(flags), m_carry * 2 + m_zero);
`endif
  endtask

  initial begin
    reset = 1'b1; in_sel = 3'b000; num1 = 8'h00; num2 = 8'h00; out_sel = 6'b000000;

    vecs.push_back(mk(1, 3'b000, 8'h00, 8'h00, 6'b000000, 8'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 3'b000, 8'h00, 8'h00, 6'b000000, 8'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 3'b000, 8'h00, 8'h00, 6'b000000, 8'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 3'b010, 8'h57, 8'h1A, 6'b000001, 8'h71, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(0, 3'b010, 8'h57, 8'h1A, 6'b000010, 8'h3D, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(0, 3'b010, 8'h57, 8'h1A, 6'b000100, 8'h12, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(0, 3'b010, 8'h57, 8'h1A, 6'b001000, 8'h5F, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(0, 3'b010, 8'h57, 8'h1A, 6'b010000, 8'h4D, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(0, 3'b010, 8'h57, 8'h1A, 6'b100000, 8'hA8, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(0, 3'b010, 8'h57, 8'h1A, 6'b000001, 8'h71, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(0, 3'b100, 8'h00, 8'h01, 6'b000001, 8'h72, 2'b10, 2'b10, 2'b00));
    vecs.push_back(mk(0, 3'b100, 8'h00, 8'h01, 6'b000001, 8'h73, 2'b10, 2'b10, 2'b00));
    vecs.push_back(mk(0, 3'b100, 8'h00, 8'h01, 6'b000001, 8'h74, 2'b10, 2'b10, 2'b00));
    vecs.push_back(mk(0, 3'b000, 8'h00, 8'h01, 6'b000001, 8'h74, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 3'b000, 8'h00, 8'h01, 6'b000001, 8'h74, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 3'b111, 8'h00, 8'h01, 6'b000001, 8'h00, 2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(0, 3'b010, 8'h57, 8'h1A, 6'b000001, 8'h71, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(0, 3'b011, 8'h57, 8'h1A, 6'b000001, 8'h00, 2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(0, 3'b010, 8'hFF, 8'h01, 6'b000001, 8'h00, 2'b01, 2'b01, 2'b11));
    vecs.push_back(mk(0, 3'b010, 8'h00, 8'h01, 6'b000010, 8'hFF, 2'b01, 2'b01, 2'b10));
    vecs.push_back(mk(0, 3'b100, 8'h00, 8'h01, 6'b000001, 8'h00, 2'b10, 2'b10, 2'b11));
    vecs.push_back(mk(0, 3'b100, 8'h00, 8'h01, 6'b000001, 8'h01, 2'b10, 2'b10, 2'b00));
    vecs.push_back(mk(1, 3'b100, 8'h00, 8'h01, 6'b000001, 8'h00, 2'b00, 2'b10, 2'b00));
    vecs.push_back(mk(0, 3'b010, 8'h57, 8'h1A, 6'b000110, 8'h3D, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(0, 3'b010, 8'h57, 8'h1A, 6'b000000, 8'h57, 2'b01, 2'b01, 2'b00));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].op);
      check($sformatf("vec%0d_out", i), int'(out), int'(vecs[i].exp_out));
      check($sformatf("vec%0d_cs", i), int'(currState), int'(vecs[i].exp_cs));
      check($sformatf("vec%0d_ns", i), int'(nextState), int'(vecs[i].exp_ns));
`ifdef ALU_FLAGS_EN
      check($sformatf("vec%0d_flags", i), int'(flags), int'(vecs[i].exp_fl));
`endif
    end

    // Reset mid-HOLD chain clears out on that very edge.
    apply(0, 3'b010, 8'h10, 8'h05, 6'b000001);
    apply(0, 3'b100, 8'h00, 8'h05, 6'b000001);
    apply(1, 3'b100, 8'h00, 8'h05, 6'b000001);
    check("midhold_reset_out", int'(out), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic       r;
      logic [5:0] op;
      r = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 1) op = 6'(1 << $urandom_range(0, 5));
      else op = 6'($urandom);
      apply(r, 3'($urandom), 8'($urandom), 8'($urandom), op);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_accum_fsm.md
Name: alu_accum_fsm

Overview:
- 8-bit ALU with a registered accumulator, sequenced by a 2-bit control FSM.
- A 3-bit mode select (persist/load/clear) picks the next FSM state. A 6-bit one-hot op select picks the ALU function.
- Result is registered into the accumulator and driven on `out`. Current and next state are exported for debug/observation.
- Leaf datapath block in the arithmetic subsystem.

Parameters:
- WIDTH, 8, operand/accumulator width (all values below assume 8).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_sel  in  3  mode select: [2]=persist, [1]=load, [0]=clear.
- num1  in  8  operand A source for LOAD.
- num2  in  8  operand B (all modes).
- out_sel  in  6  one-hot op select: [0]ADD [1]SUB [2]AND [3]OR [4]XOR [5]NOT_A.
- out  out  8  accumulator value (registered).
- currState  out  2  registered FSM state.
- nextState  out  2  combinational next state.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- State encoding: IDLE=2'b00, LOAD=2'b01, HOLD=2'b10, CLEAR=2'b11.
- nextState is combinational from in_sel, priority clear > load > persist:
  - in_sel[0]=1 -> CLEAR.
  - else in_sel[1]=1 -> LOAD.
  - else in_sel[2]=1 -> HOLD.
  - else IDLE.
- nextState tracks in_sel at all times, including during reset.
- Reset (sampled at posedge): currState<=IDLE, acc<=0x00; out=0x00 from the first edge with reset high. Reset overrides in_sel.
- Each posedge without reset: currState<=nextState, and acc updates by nextState:
  - CLEAR: acc<=0x00.
  - LOAD: acc<=alu(num1, num2).
  - HOLD: acc<=alu(acc, num2) (chained operation on stored value).
  - IDLE: acc unchanged.
- out=acc; one-cycle latency from inputs to out. No combinational input-to-out path.
- ALU functions, all results truncated to 8 bits (mod 256):
  - ADD: A+B.
  - SUB: A-B (two's complement wrap).
  - AND, OR, XOR: bitwise.
  - NOT_A: ~A (B ignored).
- out_sel not one-hot: lowest set bit wins. All-zero out_sel passes A unchanged.
- Wrap-around: 0xFF+0x01=0x00; 0x00-0x01=0xFF.
- in_sel and operands may change every cycle; no handshake.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined: adds output `flags[1:0]` = {carry, zero}, registered alongside acc and cleared by reset/CLEAR.
  - carry: bit 8 of the 9-bit sum for ADD; borrow (A<B unsigned) for SUB; 0 for logic ops.
  - zero: 1 when the new acc==0.
  - In IDLE, flags hold.
- Undefined: no flags port and no flag logic. All other behaviour identical.

Decomposition:
- Package alu_accum_pkg:
  - state encodings IDLE/LOAD/HOLD/CLEAR.
  - op bit indices OP_ADD..OP_NOT.
  - WIDTH default.
- One combinational sub-module, alu_op_unit (A, B, op_sel -> result[, carry]).
- Top holds the FSM, accumulator and operand-A mux.

Test Plan:
- Apply reset=1 for 2 cycles, then 0 with in_sel=000 -> out=0x00, currState=00, nextState=00.
- in_sel=010, num1=0x57, num2=0x1A, each op in turn:
  - ADD -> out=0x71.
  - SUB -> 0x3D.
  - AND -> 0x12.
  - OR -> 0x5F.
  - XOR -> 0x4D.
  - NOT -> 0xA8.
  - Throughout: currState=01, nextState=01.
- After LOAD ADD (acc=0x71): in_sel=100, num2=0x01, ADD for 3 cycles -> out 0x72, 0x73, 0x74; currState=10.
- in_sel=000, num1=0x00, num2=0x01 after acc=0x74 -> out holds 0x74 indefinitely; currState=00.
- in_sel=111 -> nextState=11 immediately; next edge out=0x00, currState=11. in_sel=011 also yields CLEAR (priority).
- Wrap/flags (ALU_FLAGS_EN):
  - LOAD num1=0xFF, num2=0x01, ADD -> out=0x00, flags=2'b11.
  - LOAD num1=0x00, num2=0x01, SUB -> out=0xFF, flags=2'b10.
  - Reset asserted mid-HOLD -> out=0x00 on that edge.
